// File: rtl/comp_stream_packer.sv
// comp_stream_packer
//
// Packs variable-length compressed byte chunks (0..DATA_BYTES valid bytes per
// input word) densely into full DATA_BYTES-wide AXI-stream beats. The final
// partial beat of a packet is emitted once the packet's last chunk has been
// accepted.
//
// Optional feature macro: COMP_PACKER_STATS_EN
//   When defined, adds free-running byte/beat statistics counters and their
//   output ports. When undefined, the ports and counters are absent and the
//   packing behaviour is identical.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   in_data        chunk data, valid bytes in the low lanes (byte 0 = [7:0])
//   in_nbytes      valid byte count 0..DATA_BYTES (larger values clamp)
//   in_last        last chunk of the packet
//   in_valid       chunk valid
//   in_ready       packer can accept a chunk
//   out_tdata      packed beat
//   out_tkeep      byte enables, contiguous from lane 0
//   out_tlast      final beat of the packet
//   out_tvalid     beat valid
//   out_tready     downstream ready
//   stat_bytes_in  total accepted bytes (COMP_PACKER_STATS_EN only)
//   stat_beats_out total emitted beats (COMP_PACKER_STATS_EN only)

module comp_stream_packer #(
   parameter int DATA_BYTES = 64,
   parameter int CNT_BITS   = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [8*DATA_BYTES-1:0]       in_data,
   input  logic [$clog2(DATA_BYTES):0]   in_nbytes,
   input  logic                          in_last,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [8*DATA_BYTES-1:0]       out_tdata,
   output logic [DATA_BYTES-1:0]         out_tkeep,
   output logic                          out_tlast,
   output logic                          out_tvalid,
   input  logic                          out_tready
`ifdef COMP_PACKER_STATS_EN
   ,
   output logic [CNT_BITS-1:0]           stat_bytes_in,
   output logic [CNT_BITS-1:0]           stat_beats_out
`endif
);

   localparam int NB_W   = $clog2(DATA_BYTES) + 1;
   localparam int FILL_W = $clog2(2*DATA_BYTES) + 1;
   localparam int ACC_W  = 16*DATA_BYTES;
   localparam logic [FILL_W-1:0] DB_F = FILL_W'(DATA_BYTES);

   typedef enum logic {ACCUM, FLUSH} state_t;

   state_t              state, state_next;
   logic [FILL_W-1:0]   fill, fill_next;
   logic [ACC_W-1:0]    acc, acc_next, appended;
   logic [ACC_W-1:0]    in_wide;
   logic [FILL_W-1:0]   nbytes;
   logic [FILL_W-1:0]   emitted;
   logic                accept, emit;
   logic                tvalid_next, tlast_next;
   logic [DATA_BYTES-1:0] tkeep_next;

   // Handshake qualifiers; in_ready is decoded purely from registered state.
   assign in_ready  = (state == ACCUM) && (fill <= DB_F);
   assign accept    = in_valid && in_ready;
   assign emit      = out_tvalid && out_tready;

   // The beat is always the bottom of the accumulator.
   assign out_tdata = acc[8*DATA_BYTES-1:0];

   // Clamp the byte count and zero the lanes above it, so the accumulator
   // keeps the invariant that every byte at or above fill is zero.
   always_comb begin
      nbytes  = (in_nbytes > NB_W'(DATA_BYTES)) ? DB_F : FILL_W'(in_nbytes);
      in_wide = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (FILL_W'(i) < nbytes) begin
            in_wide[8*i +: 8] = in_data[8*i +: 8];
         end
      end
   end

   // Bytes leaving on this cycle's output transfer: a full beat unless this is
   // the closing beat of a flush, which carries whatever remains.
   always_comb begin
      emitted = '0;
      if (emit) begin
         emitted = (fill < DB_F) ? fill : DB_F;
      end
   end

   // Append at the pre-shift fill, then drain the emitted bytes, then decode
   // the next output fields from the resulting state so they can be registered.
   always_comb begin
      appended = acc;
      if (accept) begin
         appended = acc | (in_wide << {fill, 3'b000});
      end
      acc_next  = appended >> {emitted, 3'b000};
      fill_next = fill + (accept ? nbytes : '0) - emitted;

      state_next = state;
      case (state)
         ACCUM: if (accept && in_last) state_next = FLUSH;
         FLUSH: if (emit && (fill <= DB_F)) state_next = ACCUM;
         default: state_next = ACCUM;
      endcase

      tvalid_next = (state_next == FLUSH) || (fill_next >= DB_F);
      tlast_next  = (state_next == FLUSH) && (fill_next <= DB_F);
      tkeep_next  = '0;
      if (tvalid_next) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            tkeep_next[i] = (FILL_W'(i) < fill_next);
         end
      end
   end

   // State, accumulator and registered output fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ACCUM;
         fill       <= '0;
         acc        <= '0;
         out_tvalid <= 1'b0;
         out_tlast  <= 1'b0;
         out_tkeep  <= '0;
      end else begin
         state      <= state_next;
         fill       <= fill_next;
         acc        <= acc_next;
         out_tvalid <= tvalid_next;
         out_tlast  <= tlast_next;
         out_tkeep  <= tkeep_next;
      end
   end

`ifdef COMP_PACKER_STATS_EN
   // Free-running statistics, cleared only by reset and wrapping naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_bytes_in  <= '0;
         stat_beats_out <= '0;
      end else begin
         if (accept) stat_bytes_in <= stat_bytes_in + CNT_BITS'(nbytes);
         if (emit)   stat_beats_out <= stat_beats_out + CNT_BITS'(1);
      end
   end
`endif

endmodule

// File: doc/comp_stream_packer.md
Name: comp_stream_packer

Overview:
- Sits downstream of the compression arbiter, directly in front of the host send stream.
- Accepts variable-length compressed byte chunks, 0..64 valid bytes per input word.
- Packs them densely into full 512-bit beats with tkeep and tlast.
- Emits the final partial beat of each packet when the packet's last chunk arrives.

Parameters:
- DATA_BYTES, 64, bytes per input word and per output beat. Power of two.
- CNT_BITS, 32, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  8*DATA_BYTES  chunk data; valid bytes in the low lanes, byte 0 = bits [7:0]
- in_nbytes  in  $clog2(DATA_BYTES)+1  valid byte count, 0..DATA_BYTES
- in_last  in  1  last chunk of the packet
- in_valid  in  1  chunk valid
- in_ready  out  1  packer can accept a chunk
- out_tdata  out  8*DATA_BYTES  packed beat
- out_tkeep  out  DATA_BYTES  byte enables, contiguous from lane 0
- out_tlast  out  1  final beat of the packet
- out_tvalid  out  1  beat valid
- out_tready  in  1  downstream ready
- stat_bytes_in  out  CNT_BITS  only with the optional feature enabled
- stat_beats_out  out  CNT_BITS  only with the optional feature enabled

Behaviour:
- Buffer: 2*DATA_BYTES-byte accumulator plus fill count `fill` (0..2*DATA_BYTES).
- Byte placement: input byte i goes to accumulator position fill+i.
- Output beat: always accumulator bytes 0..DATA_BYTES-1. After a beat is emitted, the remaining bytes shift down by the emitted count.
- Handshakes: AXI-stream style. A transfer occurs when valid && ready. out_tvalid never depends on out_tready. in_ready never depends on in_valid or out_tready.
- States: ACCUM and FLUSH.
- ACCUM:
  - in_ready = (fill <= DATA_BYTES).
  - out_tvalid = (fill >= DATA_BYTES), with out_tkeep all ones and out_tlast = 0.
  - Accepting a chunk with in_last = 1 moves the block to FLUSH.
- FLUSH:
  - in_ready = 0.
  - out_tvalid = 1.
  - If fill > DATA_BYTES: emit a full beat with tlast = 0 and stay in FLUSH.
  - Otherwise: emit min(fill, DATA_BYTES) bytes, tkeep = (1<<fill)-1, tlast = 1, then return to ACCUM with fill = 0.
- Simultaneous accept and emit in one cycle: fill_next = fill + in_nbytes - emitted.
  - Placement uses the pre-shift fill; the new bytes land at fill+i, then the whole accumulator shifts.
  - The net result must equal "append, then drain".
- Zero-length packet (in_nbytes = 0, in_last = 1, fill = 0): emit one beat with tkeep = 0, tlast = 1.
- in_nbytes = 0 with in_last = 0: accepted, no effect on data.
- in_nbytes > DATA_BYTES: treated as DATA_BYTES.
- Bytes in tdata lanes with tkeep = 0 are don't-care. The bench ignores them.
- Latency: a chunk completing a beat is visible on out_tvalid the cycle after acceptance (registered outputs).
- Backpressure: with out_tready held low, out_tdata/out_tkeep/out_tlast stay stable while out_tvalid = 1.
- Reset (any time, including mid-packet):
  - fill = 0, state = ACCUM, buffered data discarded.
  - out_tvalid = 0, out_tlast = 0, out_tkeep = 0, out_tdata = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - Statistics counters = 0.

Optional Feature:
- Macro: COMP_PACKER_STATS_EN.
- Defined:
  - stat_bytes_in adds the clamped in_nbytes on every input transfer.
  - stat_beats_out increments on every output transfer.
  - Both are free-running and wrap at 2^CNT_BITS.
  - Both are cleared only by rst.
- Undefined: both ports and their counters are absent. Packing behaviour is identical.

Test Plan:
- Aligned chunks: three chunks of 64 bytes (bytes 0x00..0xBF), last on the third, out_tready = 1 → three beats, tkeep all ones, tlast only on beat 3, data in order.
- Unaligned: chunks of 40, 40, 10 bytes, last on the third → beat 1: 64 bytes with tkeep all ones, tlast = 0; beat 2: 26 bytes, tkeep = 0x3FFFFFF, tlast = 1.
- Backpressure: same stimulus as the unaligned case, out_tready low for 5 cycles on every beat → in_ready = 0 while fill > 64; output fields stable; same data as the unbackpressured run.
- Zero-length packet: in_nbytes = 0, in_last = 1 from idle → one beat with tkeep = 0, tlast = 1. A following 64-byte packet then emits normally.
- Reset mid-packet: accept 30 bytes, assert rst for 1 cycle, then send a 20-byte last chunk → single beat with tkeep = 0xFFFFF holding only the new 20 bytes.
- Statistics (with COMP_PACKER_STATS_EN): after the unaligned scenario → stat_bytes_in = 90, stat_beats_out = 2.
